// File: rtl/ext_unit_dispatcher_pkg.sv
// Shared types for the extension-unit dispatcher.
// FSM encoding, fixed channel indices and channel-index width helper.
package ext_unit_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int CH_MUL = 0;
    localparam int CH_DIV = 1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ext_timeout_counter.sv
// Saturating cycle counter used for the busy and drain timeouts.
// expired is high on the last allowed cycle; never high when disabled.
module ext_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) &&
                     (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ext_unit_dispatcher.sv
// Dispatches one extension op at a time to a multicycle unit and
// returns its result with a done pulse; handles timeout, flush and bad channels.
module ext_unit_dispatcher
    import ext_unit_dispatcher_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int OP_WIDTH       = 3,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [ch_w(NUM_CH)-1:0]    req_ch,
    input  logic [OP_WIDTH-1:0]        req_op,
    output logic                       req_ready,
    input  logic                       flush,
    output logic [NUM_CH-1:0]          ch_valid,
    output logic [OP_WIDTH-1:0]        ch_op,
    input  logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH*DATA_W-1:0]   ch_result,
    output logic                       done,
    output logic [DATA_W-1:0]          result,
    output logic                       err,
    output logic                       busy
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ch;
    logic [OP_WIDTH-1:0] r_op;
    logic [DATA_W-1:0]   r_result;
    logic                r_err;
    logic                r_to_done;

    logic                w_legal;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic                w_sel_ready;
    logic                w_expired;
    logic                w_cnt_clear;
    logic                w_cnt_en;
    logic [DATA_W-1:0]   w_sel_result;

    assign w_legal      = {1'b0, req_ch} < NUM_CH_V;
    assign w_sel_ready  = ch_ready[r_ch];
    assign w_sel_result = ch_result[int'(r_ch) * DATA_W +: DATA_W];

    // Counter restarts on every state change, so BUSY and DRAIN each get a full period.
    assign w_cnt_clear = (w_state_nxt != r_state) || (r_state == ST_IDLE);
    assign w_cnt_en    = (r_state == ST_BUSY) || (r_state == ST_DRAIN);

    ext_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        ch_valid    = '0;
        req_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_legal ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                ch_valid = NUM_CH'(1) << r_ch;
                if (w_sel_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done        = !flush;
                w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                done = r_to_done;
                if (w_sel_ready || w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch      <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_to_done <= 1'b0;
        end else begin
            r_to_done <= w_timeout;
            if (w_accept) begin
                r_op <= req_op;
                if (w_legal) begin
                    r_ch <= req_ch;
                end else begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end
            end
            if (w_capture) begin
                r_result <= w_sel_result;
                r_err    <= 1'b0;
            end
            if (w_timeout) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
        end
    end

    assign ch_op  = r_op;
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: tb/tb_ext_unit_dispatcher.sv
// Randomized bench for ext_unit_dispatcher against a transaction-level model.
// Timing of each op is predicted from ready/flush/timeout event cycles.
module tb_ext_unit_dispatcher;
    import ext_unit_dispatcher_pkg::*;

    localparam int NCH = 3;
    localparam int OPW = 3;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [CHW-1:0]    req_ch;
    logic [OPW-1:0]    req_op;
    logic              req_ready;
    logic              flush;
    logic [NCH-1:0]    ch_valid;
    logic [OPW-1:0]    ch_op;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*DW-1:0] ch_result;
    logic              done;
    logic [DW-1:0]     result;
    logic              err;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] mres;
    logic          merr;

    ext_unit_dispatcher #(
        .NUM_CH         (NCH),
        .OP_WIDTH       (OPW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_op    (req_op),
        .req_ready (req_ready),
        .flush     (flush),
        .ch_valid  (ch_valid),
        .ch_op     (ch_op),
        .ch_ready  (ch_ready),
        .ch_result (ch_result),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Random unit traffic; the selected channel never gets a stray ready.
    task automatic drive_rand(input int sel);
        logic [NCH-1:0] m;
        m = (sel < NCH) ? ~(NCH'(1) << sel) : '1;
        req_valid = 1'b0;
        flush     = 1'b0;
        ch_ready  = NCH'($urandom) & m;
        ch_result = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".rdy"}, req_ready, 1);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".chv"}, ch_valid, 0);
        chk({tag, ".res"}, result, mres);
        chk({tag, ".err"}, err, merr);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".chv"}, ch_valid, 0);
        chk({tag, ".chop"}, ch_op, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".res"}, result, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".rdy"}, req_ready, 1);
    endtask

    // k: BUSY cycle of unit ready (0 none), f: flush cycle (0 none),
    // L: drain cycle of late ready (0 none), fd: flush during DONE.
    task automatic do_txn(input string tag, input int ch, input int op,
                          input int k, input int f, input int L,
                          input bit fd);
        int e;
        int last;
        bit k_rdy;
        bit k_to;
        logic [DW-1:0] word;
        word = '0;
        next_cycle();
        drive_rand(ch);
        req_valid = 1'b1;
        req_ch    = CHW'(ch);
        req_op    = OPW'(op);
        @(negedge clk);
        check_idle({tag, ".t0"});
        if (ch >= NCH) begin
            next_cycle();
            drive_rand(ch);
            flush = fd;
            @(negedge clk);
            chk({tag, ".ill.done"}, done, !fd);
            chk({tag, ".ill.err"}, err, 1);
            chk({tag, ".ill.res"}, result, 0);
            chk({tag, ".ill.chv"}, ch_valid, 0);
            chk({tag, ".ill.busy"}, busy, 1);
            mres = '0;
            merr = 1'b1;
            return;
        end
        e = TO;
        if (f >= 1 && f < e) e = f;
        if (k >= 1 && k <= e) e = k;
        k_rdy = (k == e);
        k_to  = !k_rdy && (e == TO);
        last  = k_rdy ? e + 1 : e + ((L >= 1 && L <= TO) ? L : TO);
        for (int c = 1; c <= last; c++) begin
            next_cycle();
            drive_rand(ch);
            if (c <= e) begin
                if (c == k) begin
                    ch_ready[ch] = 1'b1;
                    word = ch_result[ch*DW +: DW];
                end
                if (c == f) flush = 1'b1;
            end else if (k_rdy) begin
                flush = fd;
            end else if (c == e + L) begin
                ch_ready[ch] = 1'b1;
            end
            @(negedge clk);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".rdy"}, req_ready, 0);
            if (c <= e) begin
                chk({tag, ".chv"}, ch_valid, NCH'(1) << ch);
                chk({tag, ".chop"}, ch_op, op);
                chk({tag, ".done"}, done, 0);
            end else if (k_rdy) begin
                chk({tag, ".chv"}, ch_valid, 0);
                chk({tag, ".done"}, done, !fd);
                chk({tag, ".res"}, result, word);
                chk({tag, ".err"}, err, 0);
            end else begin
                chk({tag, ".dchv"}, ch_valid, 0);
                chk({tag, ".ddone"}, done, k_to && (c == e + 1));
                chk({tag, ".dres"}, result, k_to ? '0 : mres);
                chk({tag, ".derr"}, err, k_to ? 1'b1 : merr);
            end
        end
        if (k_rdy) begin
            mres = word;
            merr = 1'b0;
        end else if (k_to) begin
            mres = '0;
            merr = 1'b1;
        end
    endtask

    initial begin
        int ch;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_ch    = '0;
        req_op    = '0;
        flush     = 1'b0;
        ch_ready  = '0;
        ch_result = '0;
        mres      = '0;
        merr      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        next_cycle();
        reset = 1'b0;
        drive_rand(NCH);
        @(negedge clk);
        check_idle("post_reset");

        // MUL basic with a known result word
        next_cycle();
        drive_rand(CH_MUL);
        req_valid = 1'b1;
        req_ch    = CHW'(CH_MUL);
        req_op    = 3'd3;
        @(negedge clk);
        chk("mul.t0.rdy", req_ready, 1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            drive_rand(CH_MUL);
            if (c == 3) begin
                ch_ready[CH_MUL] = 1'b1;
                ch_result[CH_MUL*DW +: DW] = 32'h0000_0F0F;
            end
            @(negedge clk);
            chk("mul.chv", ch_valid, (c <= 3) ? 3'b001 : 3'b000);
            chk("mul.done", done, c == 4);
        end
        chk("mul.res", result, 32'h0000_0F0F);
        chk("mul.err", err, 0);
        mres = 32'h0000_0F0F;
        merr = 1'b0;

        do_txn("div", CH_DIV, 5, 4, 0, 0, 1'b0);
        do_txn("tmo", CH_MUL, 4, 0, 0, 3, 1'b0);
        do_txn("flush", CH_DIV, 1, 0, 2, 2, 1'b0);
        do_txn("after_flush", CH_MUL, 1, 1, 0, 0, 1'b0);
        do_txn("illegal", 3, 2, 0, 0, 0, 1'b0);
        do_txn("done_flush", 2, 6, 2, 0, 0, 1'b1);
        do_txn("drain_tmo", CH_DIV, 7, 0, 1, 0, 1'b0);

        // Request together with flush in IDLE is refused
        next_cycle();
        drive_rand(NCH);
        req_valid = 1'b1;
        req_ch    = '0;
        flush     = 1'b1;
        @(negedge clk);
        chk("idle_flush.rdy", req_ready, 1);
        next_cycle();
        drive_rand(NCH);
        @(negedge clk);
        check_idle("idle_flush");

        // Reset while BUSY
        do_txn("pre_rst", CH_MUL, 2, 1, 0, 0, 1'b0);
        next_cycle();
        drive_rand(CH_MUL);
        req_valid = 1'b1;
        req_ch    = CHW'(CH_MUL);
        req_op    = 3'd5;
        @(negedge clk);
        next_cycle();
        drive_rand(CH_MUL);
        @(negedge clk);
        chk("rst_busy.busy", busy, 1);
        next_cycle();
        drive_rand(CH_MUL);
        reset = 1'b1;
        @(negedge clk);
        next_cycle();
        drive_rand(CH_MUL);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_busy");
        mres = '0;
        merr = 1'b0;

        for (int i = 0; i < 150; i++) begin
            ch = ($urandom % 8 == 0) ? 3 : int'($urandom_range(0, NCH - 1));
            do_txn("rnd", ch, int'($urandom % 8),
                   ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 10)),
                   ($urandom % 3 == 0) ? int'($urandom_range(1, 10)) : 0,
                   int'($urandom_range(0, 10)),
                   ($urandom % 5 == 0));
            repeat ($urandom % 3) begin
                next_cycle();
                drive_rand(NCH);
                @(negedge clk);
                check_idle("gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
